// File: rtl/cdb_arbiter.sv
// cdb_arbiter -- round-robin arbiter driving the registered Common Data Bus.
//
// Each functional unit presents one finished result (tag + value). At most
// one result is granted per cycle and is broadcast on the CDB one cycle later.
// A tag of 0 means "no producer". Such a result is still granted so that the
// unit drains, but it is not broadcast. Instead it raises err_tag0.
//
// Ports:
//   Clock, Reset   rising-edge clock, synchronous active-high reset
//   req            per-unit result-pending flags
//   req_tag        packed tags, unit i at [i*TAG_W +: TAG_W]
//   req_data       packed values, unit i at [i*DATA_W +: DATA_W]
//   hold           consumer stall; no grant while high
//   grant          combinational one-hot acknowledge
//   cdb_valid/tag/data  registered broadcast
//   err_tag0       registered pulse: granted request carried tag 0
//   conflict_cnt   (CDB_STATS_EN only) saturating count of contended cycles
//
// Optional feature macro: CDB_STATS_EN
module cdb_arbiter #(
  parameter int NREQ   = 3,
  parameter int DATA_W = 16,
  parameter int TAG_W  = 3
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*TAG_W-1:0]  req_tag,
  input  logic [NREQ*DATA_W-1:0] req_data,
  input  logic                   hold,
  output logic [NREQ-1:0]        grant,
  output logic                   cdb_valid,
  output logic [TAG_W-1:0]       cdb_tag,
  output logic [DATA_W-1:0]      cdb_data,
`ifdef CDB_STATS_EN
  output logic [15:0]            conflict_cnt,
`endif
  output logic                   err_tag0
);

  localparam int PTR_W = $clog2(NREQ);
  localparam logic [PTR_W:0] NREQ_W = (PTR_W+1)'(NREQ);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(NREQ-1);

  logic [NREQ-1:0][TAG_W-1:0]  tag_v;
  logic [NREQ-1:0][DATA_W-1:0] data_v;
  assign tag_v  = req_tag;
  assign data_v = req_data;

  logic [PTR_W-1:0] rr_ptr, win;
  logic [PTR_W:0]   scan;
  logic             any;

  // Scan from rr_ptr upward, wrapping modulo NREQ. The first pending request wins.
  // scan carries one extra bit so rr_ptr+k can exceed NREQ-1 before the wrap.
  always_comb begin
    grant = '0;
    win   = '0;
    any   = 1'b0;
    scan  = '0;
    if (!Reset && !hold) begin
      for (int k = 0; k < NREQ; k++) begin
        scan = {1'b0, rr_ptr} + (PTR_W+1)'(k);
        if (scan >= NREQ_W) scan = scan - NREQ_W;
        if (!any && req[scan[PTR_W-1:0]]) begin
          grant[scan[PTR_W-1:0]] = 1'b1;
          win = scan[PTR_W-1:0];
          any = 1'b1;
        end
      end
    end
  end

  logic [TAG_W-1:0] win_tag;
  assign win_tag = tag_v[win];

  always_ff @(posedge Clock) begin
    if (Reset) begin
      rr_ptr    <= '0;
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      err_tag0  <= 1'b0;
    end else if (any) begin
      cdb_valid <= (win_tag != '0);
      err_tag0  <= (win_tag == '0);
      cdb_tag   <= win_tag;
      cdb_data  <= data_v[win];
      rr_ptr    <= (win == LAST) ? '0 : win + PTR_W'(1);
    end else begin
      // The tag and data registers keep their last values. Only the strobes drop.
      cdb_valid <= 1'b0;
      err_tag0  <= 1'b0;
    end
  end

`ifdef CDB_STATS_EN
  // More than one bit is set exactly when clearing the lowest set bit leaves something behind.
  logic multi;
  assign multi = |(req & (req - NREQ'(1)));

  always_ff @(posedge Clock) begin
    if (Reset)
      conflict_cnt <= '0;
    else if (!hold && multi && conflict_cnt != 16'hFFFF)
      conflict_cnt <= conflict_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
  localparam int N  = 3;
  localparam int TW = 3;
  localparam int DW = 16;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  logic hold  = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0][TW-1:0] tags  = '0;
  logic [N-1:0][DW-1:0] datas = '0;

  logic [N-1:0]  grant;
  logic          cdb_valid, err_tag0;
  logic [TW-1:0] cdb_tag;
  logic [DW-1:0] cdb_data;
`ifdef CDB_STATS_EN
  logic [15:0]   conflict_cnt;
`endif

  cdb_arbiter #(.NREQ(N), .DATA_W(DW), .TAG_W(TW)) dut (
    .Clock(Clock), .Reset(Reset), .req(req), .req_tag(tags), .req_data(datas),
    .hold(hold), .grant(grant), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data),
`ifdef CDB_STATS_EN
    .conflict_cnt(conflict_cnt),
`endif
    .err_tag0(err_tag0)
  );

  always #5 Clock = ~Clock;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a pointer to the highest-priority unit, the broadcast last produced,
  // and the contention count.
  int          m_ptr = 0;
  logic        m_valid = 1'b0, m_err = 1'b0;
  logic [TW-1:0] m_tag = '0;
  logic [DW-1:0] m_data = '0;
  logic [15:0] m_cnt = '0;
  logic        started = 1'b0;

  // The winner is the pending unit reached first when counting up from ptr
  // modulo N. The result is -1 if no grant is allowed.
  function automatic int exp_win(int ptr, logic [N-1:0] r, logic h, logic rst);
    if (rst || h) return -1;
    for (int d = 0; d < N; d++) begin
      int i = (ptr + d) % N;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_grant(int ptr, logic [N-1:0] r, logic h, logic rst);
    int w = exp_win(ptr, r, h, rst);
    logic [N-1:0] g = '0;
    if (w >= 0) g[w] = 1'b1;
    return g;
  endfunction

  always @(posedge Clock) begin
    if (Reset) begin
      started <= 1'b1;
      m_ptr <= 0; m_valid <= 1'b0; m_err <= 1'b0; m_tag <= '0; m_data <= '0; m_cnt <= '0;
    end else begin
      if (exp_win(m_ptr, req, hold, 1'b0) >= 0) begin
        m_valid <= (tags[exp_win(m_ptr, req, hold, 1'b0)] != 0);
        m_err   <= (tags[exp_win(m_ptr, req, hold, 1'b0)] == 0);
        m_tag   <= tags[exp_win(m_ptr, req, hold, 1'b0)];
        m_data  <= datas[exp_win(m_ptr, req, hold, 1'b0)];
        m_ptr   <= (exp_win(m_ptr, req, hold, 1'b0) + 1) % N;
      end else begin
        m_valid <= 1'b0;
        m_err   <= 1'b0;
      end
      if (!hold && $countones(req) > 1 && m_cnt != 16'hFFFF) m_cnt <= m_cnt + 16'd1;
    end
  end

  always @(negedge Clock) begin
    if (started) begin
      chk("m_grant", 32'(grant), 32'(exp_grant(m_ptr, req, hold, Reset)));
      chk("m_valid", 32'(cdb_valid), 32'(m_valid));
      chk("m_tag",   32'(cdb_tag),   32'(m_tag));
      chk("m_data",  32'(cdb_data),  32'(m_data));
      chk("m_err",   32'(err_tag0),  32'(m_err));
`ifdef CDB_STATS_EN
      chk("m_cnt",   32'(conflict_cnt), 32'(m_cnt));
`endif
    end
  end

  logic [N-1:0] gseq [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
  logic [TW-1:0] tseq [3] = '{3'd1, 3'd2, 3'd3};

  task automatic nxt();
    @(posedge Clock); #1;
  endtask

  initial begin
    // reset then idle
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b0;
    repeat (5) begin
      @(negedge Clock);
      chk("idle_valid", 32'(cdb_valid), 0);
      chk("idle_grant", 32'(grant), 0);
      chk("idle_tag",   32'(cdb_tag), 0);
      chk("idle_data",  32'(cdb_data), 0);
    end

    // single request from unit 1
    nxt(); req = 3'b010; tags[1] = 3'd5; datas[1] = 16'h1234;
    @(negedge Clock); chk("single_grant", 32'(grant), 32'b010);
    nxt(); req = 3'b000;
    @(negedge Clock);
    chk("single_valid", 32'(cdb_valid), 1);
    chk("single_tag",   32'(cdb_tag), 5);
    chk("single_data",  32'(cdb_data), 32'h1234);
    // pointer should now be 2; unit 0 beats unit 1 after the wrap
    nxt(); req = 3'b011;
    @(negedge Clock); chk("ptr_wrap", 32'(grant), 32'b001);
    nxt(); req = 3'b000;

    // full contention from reset
    Reset = 1'b1; nxt(); Reset = 1'b0;
    tags[0] = 3'd1; tags[1] = 3'd2; tags[2] = 3'd3;
    datas[0] = 16'h00A0; datas[1] = 16'h00B1; datas[2] = 16'h00C2;
    req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      @(negedge Clock);
      chk("rr_grant", 32'(grant), 32'(gseq[k]));
      if (k > 0) chk("rr_tag", 32'(cdb_tag), 32'(tseq[k-1]));
      nxt();
    end

    // hold stall: pointer is 1, units 0 and 2 pending
    req = 3'b101; hold = 1'b1;
    for (int h = 0; h < 3; h++) begin
      @(negedge Clock);
      chk("hold_grant", 32'(grant), 0);
      if (h > 0) chk("hold_valid", 32'(cdb_valid), 0);
      nxt();
    end
    hold = 1'b0;
    @(negedge Clock); chk("resume_grant2", 32'(grant), 32'b100);
    nxt(); req = 3'b001;
    @(negedge Clock); chk("resume_grant0", 32'(grant), 32'b001);
    nxt(); req = 3'b000;
    @(negedge Clock);
    chk("resume_tag", 32'(cdb_tag), 1);
    chk("resume_valid", 32'(cdb_valid), 1);

    // tag 0
    nxt(); tags[0] = 3'd0; req = 3'b001;
    @(negedge Clock); chk("tag0_grant", 32'(grant), 32'b001);
    nxt(); req = 3'b000;
    @(negedge Clock);
    chk("tag0_valid", 32'(cdb_valid), 0);
    chk("tag0_err",   32'(err_tag0), 1);
    nxt();
    @(negedge Clock); chk("tag0_err_clr", 32'(err_tag0), 0);

    // reset mid-stream
    nxt(); tags[0] = 3'd4; tags[1] = 3'd6; req = 3'b011; Reset = 1'b1;
    @(negedge Clock); chk("rst_grant", 32'(grant), 0);
    nxt(); Reset = 1'b0;
    @(negedge Clock);
    chk("rst_valid", 32'(cdb_valid), 0);
    chk("rst_grant0", 32'(grant), 32'b001);
`ifdef CDB_STATS_EN
    chk("cnt_after_rst", 32'(conflict_cnt), 0);
`endif
    nxt();
    @(negedge Clock);
    chk("rst_grant1", 32'(grant), 32'b010);
    chk("rst_tag4", 32'(cdb_tag), 4);
    nxt(); req = 3'b000;
    @(negedge Clock);
    chk("rst_tag6", 32'(cdb_tag), 6);
`ifdef CDB_STATS_EN
    chk("cnt_two", 32'(conflict_cnt), 2);
`endif
    repeat (3) nxt();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
